// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves instruction fetches and loads/stores
// over an 8-bit synchronous-read RAM port, one byte per cycle, MEM before IF.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_done_out,
    output logic [31:0] if_inst_out,
    input  logic        mem_req_in,
    input  logic        mem_we_in,
    input  logic [31:0] mem_addr_in,
    input  logic [1:0]  mem_len_in,
    input  logic [31:0] mem_wdata_in,
    output logic        mem_done_out,
    output logic [31:0] mem_rdata_out,
    output logic        busy_out,
    output logic [31:0] ram_addr_out,
    output logic        ram_wr_out,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    function automatic logic [2:0] len_to_count(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            2'b11:   b = w[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'b00:   r[7:0]   = b;
            2'b01:   r[15:8]  = b;
            2'b10:   r[23:16] = b;
            2'b11:   r[31:24] = b;
            default: r = w;
        endcase
        return r;
    endfunction

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [2:0]  n_r, n_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic        owner_r, owner_s;
    logic [31:0] rbuf_r, rbuf_s;
    logic [31:0] if_inst_r, if_inst_s;
    logic [31:0] mem_rdata_r, mem_rdata_s;
    logic        if_done_r, if_done_s;
    logic        mem_done_r, mem_done_s;
    logic        can_accept_s;
    logic [1:0]  cap_idx_s;

    // A byte presented at cnt=c-1 returns at cnt=c, so it lands in slot c-1 (slot 3 when cnt=4).
    assign cap_idx_s    = cnt_r[1:0] - 2'd1;
    assign can_accept_s = !if_done_r && !mem_done_r;

    // Next-state and datapath updates for the transaction FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        n_s         = n_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        owner_s     = owner_r;
        rbuf_s      = rbuf_r;
        if_inst_s   = if_inst_r;
        mem_rdata_s = mem_rdata_r;
        if_done_s   = 1'b0;
        mem_done_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (can_accept_s && mem_req_in) begin
                    owner_s = OWNER_MEM;
                    addr_s  = mem_addr_in;
                    n_s     = len_to_count(mem_len_in);
                    wdata_s = mem_wdata_in;
                    cnt_s   = 3'd0;
                    rbuf_s  = 32'd0;
                    state_s = mem_we_in ? WRITE : READ;
                end else if (can_accept_s && if_req_in) begin
                    owner_s = OWNER_IF;
                    addr_s  = if_addr_in;
                    n_s     = 3'd4;
                    wdata_s = 32'd0;
                    cnt_s   = 3'd0;
                    rbuf_s  = 32'd0;
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (cnt_r != 3'd0) begin
                    rbuf_s = put_byte(rbuf_r, cap_idx_s, ram_din);
                end else begin
                    rbuf_s = rbuf_r;
                end
                if (cnt_r == n_r) begin
                    state_s = IDLE;
                    cnt_s   = 3'd0;
                    if (owner_r == OWNER_MEM) begin
                        mem_rdata_s = rbuf_s;
                        mem_done_s  = 1'b1;
                    end else begin
                        if_inst_s = rbuf_s;
                        if_done_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            WRITE: begin
                if (cnt_r == (n_r - 3'd1)) begin
                    state_s    = IDLE;
                    cnt_s      = 3'd0;
                    mem_done_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // State and latched-operand registers; reset clears everything at once.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
            n_r         <= 3'd0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            owner_r     <= OWNER_IF;
            rbuf_r      <= 32'd0;
            if_inst_r   <= 32'd0;
            mem_rdata_r <= 32'd0;
            if_done_r   <= 1'b0;
            mem_done_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            n_r         <= n_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            owner_r     <= owner_s;
            rbuf_r      <= rbuf_s;
            if_inst_r   <= if_inst_s;
            mem_rdata_r <= mem_rdata_s;
            if_done_r   <= if_done_s;
            mem_done_r  <= mem_done_s;
        end
    end

    // RAM port decode from state, counter and latched operands only; addition wraps at 2^32.
    always_comb begin
        ram_addr_out = 32'd0;
        ram_wr_out   = 1'b0;
        ram_dout     = 8'd0;
        case (state_r)
            READ: begin
                if (cnt_r != n_r) begin
                    ram_addr_out = addr_r + {29'd0, cnt_r};
                end else begin
                    ram_addr_out = 32'd0;
                end
            end
            WRITE: begin
                ram_addr_out = addr_r + {29'd0, cnt_r};
                ram_wr_out   = 1'b1;
                ram_dout     = word_byte(wdata_r, cnt_r[1:0]);
            end
            default: begin
                ram_addr_out = 32'd0;
            end
        endcase
    end

    assign if_done_out   = if_done_r;
    assign if_inst_out   = if_inst_r;
    assign mem_done_out  = mem_done_r;
    assign mem_rdata_out = mem_rdata_r;
    assign busy_out      = (state_r != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM model answers the DUT, expected
// results are queued when a request is driven and compared on each done pulse.
module tb_mem_ctrl;

    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] if_inst_out;
    logic        mem_req_in;
    logic        mem_we_in;
    logic [31:0] mem_addr_in;
    logic [1:0]  mem_len_in;
    logic [31:0] mem_wdata_in;
    logic        mem_done_out;
    logic [31:0] mem_rdata_out;
    logic        busy_out;
    logic [31:0] ram_addr_out;
    logic        ram_wr_out;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    logic        pre_we;
    logic [31:0] pre_addr;
    logic [7:0]  pre_data;
    logic [7:0]  ram_mem   [0:1023];
    logic [7:0]  model_mem [0:1023];

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] last_mem;
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_ctrl dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .if_req_in     (if_req_in),
        .if_addr_in    (if_addr_in),
        .if_done_out   (if_done_out),
        .if_inst_out   (if_inst_out),
        .mem_req_in    (mem_req_in),
        .mem_we_in     (mem_we_in),
        .mem_addr_in   (mem_addr_in),
        .mem_len_in    (mem_len_in),
        .mem_wdata_in  (mem_wdata_in),
        .mem_done_out  (mem_done_out),
        .mem_rdata_out (mem_rdata_out),
        .busy_out      (busy_out),
        .ram_addr_out  (ram_addr_out),
        .ram_wr_out    (ram_wr_out),
        .ram_dout      (ram_dout),
        .ram_din       (ram_din)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous-read byte RAM, folded onto 1 KiB; preload port wins over DUT writes.
    always @(posedge clk_in) begin
        if (pre_we) begin
            ram_mem[pre_addr[9:0]] <= pre_data;
        end else if (ram_wr_out) begin
            ram_mem[ram_addr_out[9:0]] <= ram_dout;
        end
        ram_din <= ram_mem[ram_addr_out[9:0]];
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (if_done_out || mem_done_out) begin
            check_val("done_excl", 32'(if_done_out & mem_done_out), 32'd0);
            check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                if (if_done_out) begin
                    check_val("if_owner", 32'(mon_e.kind), 32'(K_FETCH));
                    check_val("if_inst", if_inst_out, mon_e.data);
                end else begin
                    check_val("mem_owner", 32'(mon_e.kind != K_FETCH), 32'd1);
                    check_val("mem_rdata", mem_rdata_out, mon_e.data);
                end
            end
        end
    end

    function automatic logic [2:0] n_of(input logic [1:0] len);
        return (len == 2'b00) ? 3'd1 : ((len == 2'b01) ? 3'd2 : 3'd4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] n);
        logic [31:0] r;
        logic [31:0] ba;
        r = 32'd0;
        for (int k = 0; k < int'(n); k++) begin
            ba = a + 32'(k);
            r[8*k +: 8] = model_mem[ba[9:0]];
        end
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [2:0] n, input logic [31:0] wd);
        logic [31:0] ba;
        for (int k = 0; k < int'(n); k++) begin
            ba = a + 32'(k);
            model_mem[ba[9:0]] = wd[8*k +: 8];
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        model_mem[a[9:0]] = d;
        @(posedge clk_in); #1;
        pre_we = 1'b0;
    endtask

    // Counts edges until the chosen done is seen; 40 edges is far beyond any legal latency.
    task automatic wait_done(input logic is_if, output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in); #1;
            lat++;
            if (is_if ? if_done_out : mem_done_out) break;
        end
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_fetch(input logic [31:0] a, input int exp_lat, input string tag);
        int lat;
        push_exp(K_FETCH, model_read(a, 3'd4));
        if_req_in  = 1'b1;
        if_addr_in = a;
        wait_done(1'b1, lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if_req_in = 1'b0;
        @(posedge clk_in); #1;
    endtask

    task automatic do_mem(input logic we, input logic [31:0] a, input logic [1:0] len,
                          input logic [31:0] wd, input int exp_lat, input string tag);
        int lat;
        if (we) begin
            model_write(a, n_of(len), wd);
            push_exp(K_STORE, last_mem);
        end else begin
            last_mem = model_read(a, n_of(len));
            push_exp(K_LOAD, last_mem);
        end
        mem_req_in   = 1'b1;
        mem_we_in    = we;
        mem_addr_in  = a;
        mem_len_in   = len;
        mem_wdata_in = wd;
        wait_done(1'b0, lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        mem_req_in = 1'b0;
        @(posedge clk_in); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] ea;
        rst_in       = 1'b0;
        if_req_in    = 1'b0;
        if_addr_in   = 32'd0;
        mem_req_in   = 1'b0;
        mem_we_in    = 1'b0;
        mem_addr_in  = 32'd0;
        mem_len_in   = 2'b00;
        mem_wdata_in = 32'd0;
        pre_we       = 1'b0;
        pre_addr     = 32'd0;
        pre_data     = 8'd0;
        last_mem     = 32'd0;
        for (int i = 0; i < 1024; i++) model_mem[i] = 8'd0;

        @(posedge clk_in); #1;
        preload(32'h0000_0100, 8'h13);
        preload(32'h0000_0101, 8'h05);
        preload(32'h0000_0102, 8'h10);
        preload(32'h0000_0103, 8'h00);
        preload(32'hFFFF_FFFE, 8'h11);
        preload(32'hFFFF_FFFF, 8'h22);
        preload(32'h0000_0000, 8'h33);
        preload(32'h0000_0001, 8'h44);

        check_val("rst_busy", 32'(busy_out), 32'd0);
        check_val("rst_inst", if_inst_out, 32'd0);
        check_val("rst_rdata", mem_rdata_out, 32'd0);
        check_val("rst_dones", 32'({if_done_out, mem_done_out}), 32'd0);
        check_val("rst_ram_addr", ram_addr_out, 32'd0);
        check_val("rst_ram_wr", 32'(ram_wr_out), 32'd0);

        // Release and request together: the first edge with reset high must accept.
        rst_in = 1'b1;
        do_fetch(32'h0000_0100, 6, "fetch0");
        check_val("fetch0_inst", if_inst_out, 32'h0010_0513);

        do_mem(1'b1, 32'h0000_0200, 2'b11, 32'hDEAD_BEEF, 5, "st_word");
        check_val("st_b0", 32'(ram_mem[10'h200]), 32'h0000_00EF);
        check_val("st_b1", 32'(ram_mem[10'h201]), 32'h0000_00BE);
        check_val("st_b2", 32'(ram_mem[10'h202]), 32'h0000_00AD);
        check_val("st_b3", 32'(ram_mem[10'h203]), 32'h0000_00DE);
        do_mem(1'b0, 32'h0000_0202, 2'b01, 32'd0, 4, "ld_half");
        check_val("ld_half_val", mem_rdata_out, 32'h0000_DEAD);
        do_mem(1'b0, 32'h0000_0200, 2'b10, 32'd0, 6, "ld_len10");
        do_mem(1'b1, 32'h0000_0204, 2'b00, 32'hFFFF_FFA5, 2, "st_byte");
        do_mem(1'b0, 32'h0000_0204, 2'b00, 32'd0, 3, "ld_byte");

        // Both requests in one accepting cycle: MEM first, IF starts after the done cycle.
        last_mem = model_read(32'h0000_0203, 3'd1);
        push_exp(K_LOAD, last_mem);
        push_exp(K_FETCH, model_read(32'h0000_0100, 3'd4));
        if_req_in   = 1'b1;
        if_addr_in  = 32'h0000_0100;
        mem_req_in  = 1'b1;
        mem_we_in   = 1'b0;
        mem_addr_in = 32'h0000_0203;
        mem_len_in  = 2'b00;
        wait_done(1'b0, lat);
        check_val("simul_mem_lat", 32'(lat), 32'd3);
        mem_req_in = 1'b0;
        wait_done(1'b1, lat);
        check_val("simul_if_lat", 32'(lat), 32'd7);
        if_req_in = 1'b0;
        @(posedge clk_in); #1;

        // Word load straddling the top of the address space.
        last_mem = model_read(32'hFFFF_FFFE, 3'd4);
        push_exp(K_LOAD, last_mem);
        mem_req_in  = 1'b1;
        mem_we_in   = 1'b0;
        mem_addr_in = 32'hFFFF_FFFE;
        mem_len_in  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_in); #1;
            ea = 32'hFFFF_FFFE + 32'(k);
            check_val("wrap_addr", ram_addr_out, ea);
        end
        @(posedge clk_in); #1;
        check_val("wrap_final_addr", ram_addr_out, 32'd0);
        @(posedge clk_in); #1;
        check_val("wrap_done", 32'(mem_done_out), 32'd1);
        mem_req_in = 1'b0;
        @(posedge clk_in); #1;

        // Fetch request held across its done pulse.
        push_exp(K_FETCH, model_read(32'h0000_0100, 3'd4));
        push_exp(K_FETCH, model_read(32'h0000_0100, 3'd4));
        if_req_in  = 1'b1;
        if_addr_in = 32'h0000_0100;
        wait_done(1'b1, lat);
        check_val("held_lat1", 32'(lat), 32'd6);
        @(posedge clk_in); #1;
        check_val("held_noacc", 32'(busy_out), 32'd0);
        @(posedge clk_in); #1;
        check_val("held_acc", 32'(busy_out), 32'd1);
        wait_done(1'b1, lat);
        check_val("held_lat2", 32'(lat), 32'd5);
        if_req_in = 1'b0;
        @(posedge clk_in); #1;

        // Reset after two bytes of a word store.
        mem_req_in   = 1'b1;
        mem_we_in    = 1'b1;
        mem_addr_in  = 32'h0000_0300;
        mem_len_in   = 2'b11;
        mem_wdata_in = 32'h1234_5678;
        repeat (3) begin
            @(posedge clk_in); #1;
        end
        check_val("rst_mid_pre_wr", 32'(ram_wr_out), 32'd1);
        rst_in     = 1'b0;
        mem_req_in = 1'b0;
        #1;
        check_val("rst_mid_wr", 32'(ram_wr_out), 32'd0);
        check_val("rst_mid_busy", 32'(busy_out), 32'd0);
        check_val("rst_mid_rdata", mem_rdata_out, 32'd0);
        check_val("rst_mid_b0", 32'(ram_mem[10'h300]), 32'h0000_0078);
        check_val("rst_mid_b1", 32'(ram_mem[10'h301]), 32'h0000_0056);
        last_mem = 32'd0;
        repeat (2) begin
            @(posedge clk_in); #1;
        end
        rst_in = 1'b1;
        check_val("rst_rel_busy", 32'(busy_out), 32'd0);
        do_fetch(32'h0000_0100, 6, "fetch_post_rst");

        repeat (3) begin
            @(posedge clk_in); #1;
        end
        check_val("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
